// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU op-code and execute-stage state types.
//   alu_op_e      4-bit operation code produced by ALU control
//   exec_state_e  execute-stage FSM state
//   shamt_width() shift-amount width for a given operand width
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001,
        ALU_SRA = 4'b1010,
        ALU_NOR = 4'b1100
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } exec_state_e;

    function automatic int shamt_width(input int xlen);
        return $clog2(xlen);
    endfunction

    localparam int XLEN_DEFAULT = 32;
    localparam int SHAMT_W      = shamt_width(XLEN_DEFAULT);

endpackage

// File: rtl/alu_shift_iter.sv
// alu_shift_iter: iterative one-bit-per-cycle shifter for the execute stage.
//   clk, rst_n  clock, asynchronous active-low reset
//   load_i      capture a_i, shamt_i and op_i into the working registers
//   step_i      shift the working register by one and decrement the count
//   op_i        ALU_SLL / ALU_SRL / ALU_SRA selects direction and fill
//   a_i         value to shift
//   shamt_i     number of single-bit steps to perform (non-zero when loaded)
//   next_o      working register after one more step
//   last_o      the coming step is the final one
module alu_shift_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SW   = shamt_width(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_i,
    input  logic            step_i,
    input  alu_op_e         op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [SW-1:0]   shamt_i,
    output logic [XLEN-1:0] next_o,
    output logic            last_o
);

    logic [XLEN-1:0] work_q;
    logic [SW-1:0]   cnt_q;
    logic            left_q;
    logic            arith_q;

    // Right shifts fill with the sign bit only for SRA.
    assign next_o = left_q ? {work_q[XLEN-2:0], 1'b0}
                           : {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
    assign last_o = cnt_q == SW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else if (load_i) begin
            work_q  <= a_i;
            cnt_q   <= shamt_i;
            left_q  <= op_i == ALU_SLL;
            arith_q <= op_i == ALU_SRA;
        end else if (step_i) begin
            work_q  <= next_o;
            cnt_q   <= cnt_q - SW'(1);
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: registered ALU execute stage with valid/ready handshake on both sides.
// Optional iterative shifts are built when ALU_EXEC_SHIFT_EN is defined.
//   clk, rst_n    clock, asynchronous active-low reset
//   in_valid      operation and operands present
//   in_ready      stage accepts an operation this cycle
//   ALUoperation  4-bit op code (AND/OR/ADD/SUB/SLT/NOR, SLL/SRL/SRA when enabled)
//   a, b          operands; shift amount is b[log2(XLEN)-1:0]
//   out_valid     result register holds an unconsumed result
//   out_ready     consumer takes the result this cycle
//   result, zero  registered result and result==0 flag
//   busy          iterative shift in progress
module alu_exec
    import alu_pkg::*;
#(
    parameter int N    = 4,
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    ALUoperation,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    localparam int SW = shamt_width(XLEN);

    exec_state_e     state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            res_we;
    logic            zero_q;
    logic            valid_q;
    logic [XLEN-1:0] alu_res;
    logic            accept;
    logic            start_shift;
    logic            shift_done;
    logic [XLEN-1:0] shift_next;
    alu_op_e         op;

    assign op       = alu_op_e'(ALUoperation);
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_HOLD && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_AND: alu_res = a & b;
            ALU_OR:  alu_res = a | b;
            ALU_ADD: alu_res = a + b;
            ALU_SUB: alu_res = a - b;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_NOR: alu_res = ~(a | b);
`ifdef ALU_EXEC_SHIFT_EN
            // A zero shift amount completes immediately with a unchanged;
            // non-zero amounts go through the iterative shifter instead.
            ALU_SLL, ALU_SRL, ALU_SRA: alu_res = a;
`endif
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_EXEC_SHIFT_EN
    logic [SW-1:0] shamt;
    logic          is_shift;
    logic          shift_last;
    logic          busy_q;

    assign shamt       = b[SW-1:0];
    assign is_shift    = op == ALU_SLL || op == ALU_SRL || op == ALU_SRA;
    assign start_shift = accept && is_shift && shamt != '0;
    assign shift_done  = state_q == ST_SHIFT && shift_last;
    assign busy        = busy_q;

    alu_shift_iter #(.XLEN(XLEN), .SW(SW)) u_shift (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (start_shift),
        .step_i  (state_q == ST_SHIFT),
        .op_i    (op),
        .a_i     (a),
        .shamt_i (shamt),
        .next_o  (shift_next),
        .last_o  (shift_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= state_d == ST_SHIFT;
    end
`else
    assign start_shift = 1'b0;
    assign shift_done  = 1'b0;
    assign shift_next  = '0;
    assign busy        = 1'b0;
`endif

    // An accept in HOLD with out_ready replaces the consumed result in the
    // same edge, which is what gives back-to-back throughput without a bubble.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        res_we   = 1'b0;
        if (start_shift) begin
            state_d = ST_SHIFT;
        end else if (accept) begin
            state_d  = ST_HOLD;
            result_d = alu_res;
            res_we   = 1'b1;
        end else if (shift_done) begin
            state_d  = ST_HOLD;
            result_d = shift_next;
            res_we   = 1'b1;
        end else if (state_q == ST_HOLD && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            valid_q <= state_d == ST_HOLD;
            if (res_we) begin
                result_q <= result_d;
                zero_q   <= result_d == '0;
            end
        end
    end

    assign out_valid = valid_q;
    assign result    = result_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized checks of alu_exec against a behavioural model.
module tb_alu_exec;

`ifdef ALU_EXEC_SHIFT_EN
    localparam bit SH = 1'b1;
`else
    localparam bit SH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        in_ready, out_valid, zero, busy;
    logic [31:0] result;

    int n_vec = 0;
    int n_err = 0;

    alu_exec #(.N(4), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUoperation (op),
        .a            (a),
        .b            (b),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .result       (result),
        .zero         (zero),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_f(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        int s;
        s = int'(y[4:0]);
        case (o)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0111: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b1100: return ~(x | y);
            4'b1000: return SH ? x << s : 32'd0;
            4'b1001: return SH ? x >> s : 32'd0;
            4'b1010: return SH ? 32'($signed(x) >>> s) : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit is_shift(input logic [3:0] o);
        return SH && (o == 4'b1000 || o == 4'b1001 || o == 4'b1010);
    endfunction

    // Model: an output slot plus a countdown of remaining shift cycles.
    bit          m_valid = 1'b0;
    bit          m_acc = 1'b0;
    bit          m_rdy;
    int          m_busy = 0;
    logic [31:0] m_res = '0;
    logic [31:0] m_pend = '0;
    logic [31:0] m_r;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_busy  = 0;
            m_acc   = 1'b0;
        end else begin
            m_rdy = (!m_valid && m_busy == 0) || (m_valid && out_ready);
            m_acc = in_valid && m_rdy;
            if (m_busy > 0) begin
                m_busy = m_busy - 1;
                if (m_busy == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                end
            end else if (m_valid && out_ready && !m_acc) begin
                m_valid = 1'b0;
            end
            if (m_acc) begin
                m_r = ref_f(op, a, b);
                if (is_shift(op) && b[4:0] != 5'd0) begin
                    m_busy  = int'(b[4:0]);
                    m_pend  = m_r;
                    m_valid = 1'b0;
                end else begin
                    m_valid = 1'b1;
                    m_res   = m_r;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        check("in_ready", 32'(in_ready), 32'((!m_valid && m_busy == 0) || (m_valid && out_ready)));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_busy > 0));
        if (m_valid) begin
            check("result", result, m_res);
            check("zero", 32'(zero), 32'(m_res == 32'd0));
        end
    end

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk);
            #1;
            if (m_acc) break;
        end
        if (!m_acc) check("accept_timeout", 32'(m_acc), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_valid(output int cyc, output int bsy);
        cyc = 0;
        bsy = 0;
        #2;
        while (out_valid !== 1'b1 && cyc < 60) begin
            if (busy === 1'b1) bsy++;
            @(negedge clk);
            #2;
            cyc++;
        end
        if (cyc >= 60) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic run(input string nm, input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] exp, input int exp_lat);
        int cyc, bsy;
        out_ready = 1'b0;
        issue(o, x, y);
        wait_valid(cyc, bsy);
        check(nm, result, exp);
        check({nm, "_zero"}, 32'(zero), 32'(exp == 32'd0));
        check({nm, "_lat"}, cyc, exp_lat);
        check({nm, "_busy"}, bsy, exp_lat);
        @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int r;
        logic [3:0] ops [10];
        logic [31:0] corner [5];
        ops = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1001, 4'b1010, 4'b0011};
        corner = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};

        repeat (3) @(negedge clk);
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0);
        run("sub_eq", 4'b0110, 32'd5, 32'd5, 32'd0, 0);
        run("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        run("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 0);
        run("nor_00", 4'b1100, 32'd0, 32'd0, 32'hFFFF_FFFF, 0);
        run("undef", 4'b0101, 32'h1234, 32'h5678, 32'd0, 0);

        // Hold for three cycles with a competing op waiting, then no-bubble follow-ons.
        out_ready = 1'b0;
        issue(4'b0000, 32'h0000_F0F0, 32'h0000_FF00);
        op = 4'b0001;
        a = 32'h0000_F0F0;
        b = 32'h0000_FF00;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check("hold_result", result, 32'h0000_F000);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        check("b2b_or", result, 32'h0000_FFF0);
        check("b2b_or_valid", 32'(out_valid), 32'd1);
        op = 4'b0010;
        a = 32'd1;
        b = 32'd2;
        @(negedge clk);
        #2;
        check("b2b_add", result, 32'd3);
        check("b2b_add_valid", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b0;
        @(negedge clk);

`ifdef ALU_EXEC_SHIFT_EN
        run("sra4", 4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 4);
        run("sll0", 4'b1000, 32'h1234_5678, 32'd0, 32'h1234_5678, 0);
        run("srl31", 4'b1001, 32'h8000_0000, 32'd31, 32'h1, 31);
        run("sll_mask", 4'b1000, 32'h1, 32'h0000_0023, 32'h8, 3);
        issue(4'b1000, 32'h1, 32'd10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_shift_valid", 32'(out_valid), 32'd0);
        check("rst_shift_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            #2;
            check("post_rst_valid", 32'(out_valid), 32'd0);
        end
`else
        run("sll_off", 4'b1000, 32'hFFFF, 32'd3, 32'd0, 0);
        run("sra_off", 4'b1010, 32'h8000_0000, 32'd4, 32'd0, 0);
`endif
        @(negedge clk);
        out_ready = 1'b0;
        issue(4'b0010, 32'd1, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_hold_valid", 32'(out_valid), 32'd0);
        check("rst_hold_result", result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 1500; i++) begin
            in_valid = $urandom_range(0, 9) < 7;
            r = int'($urandom_range(0, 9));
            op = (r == 9) ? 4'($urandom) : ops[r];
            a = $urandom_range(0, 3) == 0 ? corner[$urandom_range(0, 4)] : $urandom;
            b = $urandom_range(0, 1) == 0 ? $urandom : 32'($urandom_range(0, 40));
            out_ready = $urandom_range(0, 9) < 7;
            rst_n = $urandom_range(0, 299) != 0;
            @(negedge clk);
        end
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
